// File: rtl/foursprite_compositor_if.sv
// Bundles the pixel-timing inputs, sprite configuration, sprite ROM port and
// composited outputs of foursprite_compositor into one port.
interface foursprite_compositor_if #(
  parameter int SPR_BITS = 5,
  parameter int ADDR_W   = 2 + 2*SPR_BITS
);
  logic              frame_start;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic              blank_in;
  logic              hs_in;
  logic              vs_in;
  logic [39:0]       spr_x;
  logic [39:0]       spr_y;
  logic [3:0]        spr_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        pixel_index;
  logic              blank_out;
  logic              hs_out;
  logic              vs_out;
  logic              collision;

  modport slave (
    input  frame_start, draw_x, draw_y, blank_in, hs_in, vs_in,
    input  spr_x, spr_y, spr_en, rom_data,
    output rom_addr, pixel_index, blank_out, hs_out, vs_out, collision
  );

  modport master (
    output frame_start, draw_x, draw_y, blank_in, hs_in, vs_in,
    output spr_x, spr_y, spr_en, rom_data,
    input  rom_addr, pixel_index, blank_out, hs_out, vs_out, collision
  );
endinterface

// File: rtl/foursprite_compositor.sv
// Four-sprite hit test, priority select and ROM lookup producing a palette index;
// 2-cycle latency from draw coordinate to pixel_index, one pixel per clock, never stalls.
module foursprite_compositor #(
  parameter int SPR_BITS = 5,
  parameter int ADDR_W   = 2 + 2*SPR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  foursprite_compositor_if.slave bus
);
  localparam logic [10:0] SIDE = 11'(1 << SPR_BITS);

  logic [3:0][9:0]   sx_q, sx_d, sy_q, sy_d;
  logic [3:0]        en_q, en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d1_d;
  logic              blank_d1_q, blank_d1_d;
  logic              hs_d1_q, hs_d1_d;
  logic              vs_d1_q, vs_d1_d;
  logic [3:0]        pixel_index_q, pixel_index_d;
  logic              blank_out_q, blank_out_d;
  logic              hs_out_q, hs_out_d;
  logic              vs_out_q, vs_out_d;
  logic              ovl_q, ovl_d;
  logic              collision_q, collision_d;

  logic [3:0][10:0]  dx, dy;
  logic [3:0]        hit;
  logic              sel_vld;
  logic [1:0]        sel_id;
  logic              overlap;

  // 11-bit offsets keep a box hanging past column/row 1023 from wrapping to 0.
  always_comb begin
    dx  = '0;
    dy  = '0;
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      dx[i]  = {1'b0, bus.draw_x} - {1'b0, sx_q[i]};
      dy[i]  = {1'b0, bus.draw_y} - {1'b0, sy_q[i]};
      hit[i] = en_q[i]
             && (bus.draw_x >= sx_q[i]) && (dx[i] < SIDE)
             && (bus.draw_y >= sy_q[i]) && (dy[i] < SIDE);
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        sel_vld = 1'b1;
        sel_id  = 2'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more sprites hit.
  assign overlap = bus.blank_in && ((hit & (hit - 4'd1)) != 4'd0);

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    en_d = en_q;
    if (bus.frame_start) begin
      sx_d = bus.spr_x;
      sy_d = bus.spr_y;
      en_d = bus.spr_en;
    end

    rom_addr_d = rom_addr_q;
    if (sel_vld) begin
      rom_addr_d = {sel_id, dy[sel_id][SPR_BITS-1:0], dx[sel_id][SPR_BITS-1:0]};
    end
    hit_d1_d   = sel_vld;
    blank_d1_d = bus.blank_in;
    hs_d1_d    = bus.hs_in;
    vs_d1_d    = bus.vs_in;

    pixel_index_d = (blank_d1_q && hit_d1_q) ? bus.rom_data : 4'h0;
    blank_out_d   = blank_d1_q;
    hs_out_d      = hs_d1_q;
    vs_out_d      = vs_d1_q;

    // The frame_start clear beats a same-cycle set, but that overlap still reaches collision.
    collision_d = collision_q;
    ovl_d       = ovl_q | overlap;
    if (bus.frame_start) begin
      collision_d = ovl_q | overlap;
      ovl_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q          <= '0;
      sy_q          <= '0;
      en_q          <= '0;
      rom_addr_q    <= '0;
      hit_d1_q      <= 1'b0;
      blank_d1_q    <= 1'b0;
      hs_d1_q       <= 1'b0;
      vs_d1_q       <= 1'b0;
      pixel_index_q <= 4'h0;
      blank_out_q   <= 1'b0;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      ovl_q         <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      en_q          <= en_d;
      rom_addr_q    <= rom_addr_d;
      hit_d1_q      <= hit_d1_d;
      blank_d1_q    <= blank_d1_d;
      hs_d1_q       <= hs_d1_d;
      vs_d1_q       <= vs_d1_d;
      pixel_index_q <= pixel_index_d;
      blank_out_q   <= blank_out_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
      ovl_q         <= ovl_d;
      collision_q   <= collision_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.pixel_index = pixel_index_q;
  assign bus.blank_out   = blank_out_q;
  assign bus.hs_out      = hs_out_q;
  assign bus.vs_out      = vs_out_q;
  assign bus.collision   = collision_q;
endmodule
